// File: rtl/phy_tx_pkg.sv
// Shared GT PHY framing constants and word builders for the transmit path.
// Byte 0 ([7:0]) is the first byte on the wire; charisk bit n flags byte n.
package phy_tx_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] D16_2 = 8'h50;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  charisk;
   } gt_word_t;

   localparam gt_word_t IDLE_WORD = '{data: {D16_2, K28_5, D16_2, K28_5}, charisk: 4'b0101};
   localparam gt_word_t SOF_WORD  = '{data: {K27_7, D16_2, K28_5, K28_5}, charisk: 4'b1011};
   localparam gt_word_t EOF_WORD  = '{data: {24'h000000, K29_7}, charisk: 4'b0001};

   // AXI beats are big-endian; the wire wants the first byte in [7:0].
   function automatic logic [31:0] byte_rev(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic gt_word_t payload_word(input logic [31:0] d);
      gt_word_t w;
      w.data    = byte_rev(d);
      w.charisk = 4'b0000;
      return w;
   endfunction

   // Only called for the three partial keeps; anything else is handled as full.
   function automatic gt_word_t tail_word(input logic [3:0] keep, input logic [31:0] d);
      gt_word_t w;
      case (keep)
         4'b1110: w = '{data: {K29_7, d[15:8], d[23:16], d[31:24]}, charisk: 4'b1000};
         4'b1100: w = '{data: {8'h00, K29_7, d[23:16], d[31:24]}, charisk: 4'b0100};
         default: w = '{data: {8'h00, 8'h00, K29_7, d[31:24]}, charisk: 4'b0010};
      endcase
      return w;
   endfunction

   function automatic logic keep_is_partial(input logic [3:0] keep);
      return (keep == 4'b1110) || (keep == 4'b1100) || (keep == 4'b1000);
   endfunction

endpackage

// File: rtl/phy_tx.sv
// GT PHY transmit framer: wraps AXI-Stream frames in SOF / K29.7 terminator
// and fills the gaps with idle comma words. All outputs are registered.
module phy_tx
   import phy_tx_pkg::*;
#(
   parameter int unsigned P_MIN_IDLE = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_link_up,
   input  logic        i_axi_s_valid,
   input  logic        i_axi_s_last,
   input  logic [3:0]  i_axi_s_keep,
   input  logic [31:0] i_axi_s_data,
   output logic        o_axi_s_ready,
   output logic [31:0] o_gt_tx_data,
   output logic [3:0]  o_gt_tx_charisk,
   output logic        o_underrun
);

   localparam logic [2:0] ST_GAP  = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_EOF  = 3'd3;
   localparam logic [2:0] ST_DROP = 3'd4;

   localparam logic [3:0] MIN_IDLE = 4'(P_MIN_IDLE);

   logic [2:0] state_q, state_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   gt_word_t   word_q, word_d;
   logic       ready_q, ready_d;
   logic       underrun_q, underrun_d;

   logic [3:0] gap_cnt_inc;
   logic       last_partial;

   // Counter tracks IDLE words already committed since the EOF-carrying word.
   assign gap_cnt_inc  = (gap_cnt_q == 4'hF) ? gap_cnt_q : gap_cnt_q + 4'd1;
   assign last_partial = i_axi_s_last && keep_is_partial(i_axi_s_keep);

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      word_d     = IDLE_WORD;
      ready_d    = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         ST_GAP: begin
            gap_cnt_d = gap_cnt_inc;
            if (gap_cnt_inc >= MIN_IDLE) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (i_link_up && i_axi_s_valid) begin
               word_d  = SOF_WORD;
               ready_d = 1'b1;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (i_axi_s_valid) begin
               if (!i_axi_s_last) begin
                  word_d  = payload_word(i_axi_s_data);
                  ready_d = 1'b1;
               end else if (!last_partial) begin
                  word_d  = payload_word(i_axi_s_data);
                  state_d = ST_EOF;
               end else begin
                  word_d    = tail_word(i_axi_s_keep, i_axi_s_data);
                  gap_cnt_d = 4'd0;
                  state_d   = ST_GAP;
               end
            end else begin
               // No flow control on the link: a bubble truncates the frame.
               word_d     = EOF_WORD;
               underrun_d = 1'b1;
               ready_d    = 1'b1;
               gap_cnt_d  = 4'd0;
               state_d    = ST_DROP;
            end
         end
         ST_EOF: begin
            word_d    = EOF_WORD;
            gap_cnt_d = 4'd0;
            state_d   = ST_GAP;
         end
         ST_DROP: begin
            ready_d   = 1'b1;
            gap_cnt_d = gap_cnt_inc;
            if (i_axi_s_valid && i_axi_s_last) begin
               ready_d = 1'b0;
               state_d = ST_GAP;
            end
         end
         default: begin
            gap_cnt_d = 4'd0;
            state_d   = ST_GAP;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_GAP;
         gap_cnt_q  <= 4'd0;
         word_q     <= IDLE_WORD;
         ready_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         word_q     <= word_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
      end
   end

   assign o_axi_s_ready   = ready_q;
   assign o_gt_tx_data    = word_q.data;
   assign o_gt_tx_charisk = word_q.charisk;
   assign o_underrun      = underrun_q;

endmodule
